// File: rtl/ifu_bht_update_ctl_if.sv
// Branch-resolution update bus between EXU and the IFU BHT update controller,
// together with the BHT write port and the statistics the controller exports.
interface ifu_bht_update_ctl_if #(
  parameter int BHT_IDX_W = 8
);
  logic                 upd_valid;
  logic [BHT_IDX_W-1:0] upd_index;
  logic                 upd_way;
  logic [1:0]           upd_hist;
  logic                 upd_ataken;
  logic                 upd_misp;
  logic                 bht_rd_busy;
  logic                 stat_clr;
  logic                 bht_wr_en;
  logic [BHT_IDX_W-1:0] bht_wr_addr;
  logic                 bht_wr_way;
  logic [1:0]           bht_wr_data;
  logic                 fifo_full;
  logic [31:0]          upd_cnt;
  logic [31:0]          misp_cnt;
  logic [15:0]          drop_cnt;

  modport master (
    output upd_valid, upd_index, upd_way, upd_hist, upd_ataken, upd_misp,
    output bht_rd_busy, stat_clr,
    input  bht_wr_en, bht_wr_addr, bht_wr_way, bht_wr_data,
    input  fifo_full, upd_cnt, misp_cnt, drop_cnt
  );

  modport slave (
    input  upd_valid, upd_index, upd_way, upd_hist, upd_ataken, upd_misp,
    input  bht_rd_busy, stat_clr,
    output bht_wr_en, bht_wr_addr, bht_wr_way, bht_wr_data,
    output fifo_full, upd_cnt, misp_cnt, drop_cnt
  );
endinterface

// File: rtl/ifu_bht_update_ctl.sv
// Buffers resolved-branch BHT updates in a small coalescing FIFO and drains them
// to the BHT write port whenever fetch is not reading the array; keeps branch stats.
module ifu_bht_update_ctl #(
  parameter int BHT_IDX_W = 8,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_l,
  ifu_bht_update_ctl_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [BHT_IDX_W-1:0] index;
    logic                 way;
    logic [1:0]           hist;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q, tail_ptr;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q;
  logic [31:0]        upd_cnt_q, misp_cnt_q;
  logic [15:0]        drop_cnt_q;

  entry_t head, newest;
  logic   empty, at_cap, pop, newest_hit, coalesce, push, drop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    empty      = (count_q == '0);
    at_cap     = (count_q == CNT_FULL);
    tail_ptr   = wr_ptr_q - PTR_ONE;
    head       = mem_q[rd_ptr_q];
    newest     = mem_q[tail_ptr];
    pop        = ~empty & ~bus.bht_rd_busy;
    newest_hit = ~empty & (newest.index == bus.upd_index) & (newest.way == bus.upd_way);
    // A matching newest entry that is leaving this cycle cannot absorb the update.
    coalesce   = bus.upd_valid & newest_hit & ~(pop & (count_q == CNT_ONE));
    push       = bus.upd_valid & ~coalesce & (~at_cap | pop);
    drop       = bus.upd_valid & ~coalesce & ~push;
    count_d    = count_q;
    if (push & ~pop)      count_d = count_q + CNT_ONE;
    else if (pop & ~push) count_d = count_q - CNT_ONE;
  end

  // NOTE: the storage array has no reset; occupancy gates every read, so stale data is never used.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{index: bus.upd_index, way: bus.upd_way, hist: bus.upd_hist};
    end else if (coalesce) begin
      mem_q[tail_ptr].hist <= bus.upd_hist;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      upd_cnt_q  <= '0;
      misp_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);

      if (bus.stat_clr) begin
        upd_cnt_q  <= '0;
        misp_cnt_q <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (bus.upd_valid)                upd_cnt_q  <= upd_cnt_q + 32'd1;
        if (bus.upd_valid & bus.upd_misp) misp_cnt_q <= misp_cnt_q + 32'd1;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // Actual-taken travels with the update for debug visibility only.
  logic unused_ataken;
  assign unused_ataken = bus.upd_ataken;

  assign bus.bht_wr_en   = pop;
  assign bus.bht_wr_addr = empty ? '0   : head.index;
  assign bus.bht_wr_way  = empty ? 1'b0 : head.way;
  assign bus.bht_wr_data = empty ? 2'b0 : head.hist;
  assign bus.fifo_full   = full_q;
  assign bus.upd_cnt     = upd_cnt_q;
  assign bus.misp_cnt    = misp_cnt_q;
  assign bus.drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_ifu_bht_update_ctl.sv
// Self-checking bench: per-cycle vector table plus hand-written corner sequences,
// with a scoreboard of expected BHT writes checked on every drained entry.
`timescale 1ns/1ps
module tb_ifu_bht_update_ctl;

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  ifu_bht_update_ctl_if #(.BHT_IDX_W(8)) bus ();

  ifu_bht_update_ctl #(.BHT_IDX_W(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] addr;
    logic       way;
    logic [1:0] data;
  } wr_t;

  wr_t sb_q[$];

  // Every drained entry must be the next expected write, in order.
  always @(negedge clk) begin
    if (rst_l && bus.bht_wr_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", {22'd0, bus.bht_wr_addr, bus.bht_wr_way, bus.bht_wr_data}, 32'd0);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("sb_write", {21'd0, bus.bht_wr_addr, bus.bht_wr_way, bus.bht_wr_data},
              {21'd0, e.addr, e.way, e.data});
      end
    end
  end

  task automatic drive(input logic b, input logic v, input logic [7:0] idx, input logic w,
                       input logic [1:0] h, input logic m, input logic c);
    @(posedge clk);
    #1;
    bus.bht_rd_busy = b;
    bus.upd_valid   = v;
    bus.upd_index   = idx;
    bus.upd_way     = w;
    bus.upd_hist    = h;
    bus.upd_ataken  = h[1];
    bus.upd_misp    = m;
    bus.stat_clr    = c;
  endtask

  typedef struct {
    logic        busy, v;
    logic [7:0]  idx;
    logic        w;
    logic [1:0]  h;
    logic        sb;
    logic        ewr;
    logic [7:0]  eaddr;
    logic [1:0]  edata;
    logic        efull;
    logic [31:0] eupd;
    logic [15:0] edrop;
  } vec_t;

  function automatic vec_t mk(input logic busy, input logic v, input logic [7:0] idx,
                              input logic w, input logic [1:0] h, input logic sb,
                              input logic ewr, input logic [7:0] eaddr, input logic [1:0] edata,
                              input logic efull, input logic [31:0] eupd, input logic [15:0] edrop);
    vec_t r;
    r = '{busy, v, idx, w, h, sb, ewr, eaddr, edata, efull, eupd, edrop};
    return r;
  endfunction

  vec_t vecs[31];

  initial begin
    // Inputs apply after the edge; expectations are the outputs seen later in that same cycle.
    vecs[0]  = mk(0,1,8'h12,0,2'b10,1, 0,8'h00,2'b00,0, 0,0);
    vecs[1]  = mk(0,0,8'h00,0,2'b00,0, 1,8'h12,2'b10,0, 1,0);
    vecs[2]  = mk(0,0,8'h00,0,2'b00,0, 0,8'h00,2'b00,0, 1,0);
    vecs[3]  = mk(1,1,8'h01,0,2'b01,1, 0,8'h00,2'b00,0, 1,0);
    vecs[4]  = mk(1,1,8'h02,0,2'b01,1, 0,8'h01,2'b01,0, 2,0);
    vecs[5]  = mk(1,1,8'h03,0,2'b01,1, 0,8'h01,2'b01,0, 3,0);
    vecs[6]  = mk(1,1,8'h04,0,2'b01,1, 0,8'h01,2'b01,0, 4,0);
    vecs[7]  = mk(1,1,8'h05,0,2'b01,0, 0,8'h01,2'b01,1, 5,0);
    vecs[8]  = mk(0,0,8'h00,0,2'b00,0, 1,8'h01,2'b01,1, 6,1);
    vecs[9]  = mk(0,0,8'h00,0,2'b00,0, 1,8'h02,2'b01,0, 6,1);
    vecs[10] = mk(0,0,8'h00,0,2'b00,0, 1,8'h03,2'b01,0, 6,1);
    vecs[11] = mk(0,0,8'h00,0,2'b00,0, 1,8'h04,2'b01,0, 6,1);
    vecs[12] = mk(0,0,8'h00,0,2'b00,0, 0,8'h00,2'b00,0, 6,1);
    vecs[13] = mk(1,1,8'h07,0,2'b01,0, 0,8'h00,2'b00,0, 6,1);
    vecs[14] = mk(1,1,8'h07,0,2'b11,1, 0,8'h07,2'b01,0, 7,1);
    vecs[15] = mk(0,0,8'h00,0,2'b00,0, 1,8'h07,2'b11,0, 8,1);
    vecs[16] = mk(0,0,8'h00,0,2'b00,0, 0,8'h00,2'b00,0, 8,1);
    vecs[17] = mk(1,1,8'h20,0,2'b10,1, 0,8'h00,2'b00,0, 8,1);
    vecs[18] = mk(1,1,8'h21,0,2'b10,1, 0,8'h20,2'b10,0, 9,1);
    vecs[19] = mk(1,1,8'h22,0,2'b10,1, 0,8'h20,2'b10,0, 10,1);
    vecs[20] = mk(1,1,8'h23,0,2'b10,1, 0,8'h20,2'b10,0, 11,1);
    vecs[21] = mk(0,1,8'h09,1,2'b01,1, 1,8'h20,2'b10,1, 12,1);
    vecs[22] = mk(0,0,8'h00,0,2'b00,0, 1,8'h21,2'b10,1, 13,1);
    vecs[23] = mk(0,0,8'h00,0,2'b00,0, 1,8'h22,2'b10,0, 13,1);
    vecs[24] = mk(0,0,8'h00,0,2'b00,0, 1,8'h23,2'b10,0, 13,1);
    vecs[25] = mk(0,0,8'h00,0,2'b00,0, 1,8'h09,2'b01,0, 13,1);
    vecs[26] = mk(0,0,8'h00,0,2'b00,0, 0,8'h00,2'b00,0, 13,1);
    vecs[27] = mk(1,1,8'h30,0,2'b01,1, 0,8'h00,2'b00,0, 13,1);
    vecs[28] = mk(0,1,8'h30,0,2'b10,1, 1,8'h30,2'b01,0, 14,1);
    vecs[29] = mk(0,0,8'h00,0,2'b00,0, 1,8'h30,2'b10,0, 15,1);
    vecs[30] = mk(0,0,8'h00,0,2'b00,0, 0,8'h00,2'b00,0, 15,1);

    rst_l           = 1'b0;
    bus.upd_valid   = 1'b0;
    bus.upd_index   = '0;
    bus.upd_way     = 1'b0;
    bus.upd_hist    = '0;
    bus.upd_ataken  = 1'b0;
    bus.upd_misp    = 1'b0;
    bus.bht_rd_busy = 1'b0;
    bus.stat_clr    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_l = 1'b1;
    @(negedge clk);
    check("rst_wr_en",    32'(bus.bht_wr_en), 32'd0);
    check("rst_full",     32'(bus.fifo_full), 32'd0);
    check("rst_upd_cnt",  bus.upd_cnt,        32'd0);
    check("rst_misp_cnt", bus.misp_cnt,       32'd0);
    check("rst_drop_cnt", 32'(bus.drop_cnt),  32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].busy, vecs[i].v, vecs[i].idx, vecs[i].w, vecs[i].h, 1'b0, 1'b0);
      if (vecs[i].sb) sb_q.push_back('{vecs[i].idx, vecs[i].w, vecs[i].h});
      @(negedge clk);
      check($sformatf("v%0d_wr_en", i), 32'(bus.bht_wr_en),   32'(vecs[i].ewr));
      check($sformatf("v%0d_addr", i),  32'(bus.bht_wr_addr), 32'(vecs[i].eaddr));
      check($sformatf("v%0d_data", i),  32'(bus.bht_wr_data), 32'(vecs[i].edata));
      check($sformatf("v%0d_full", i),  32'(bus.fifo_full),   32'(vecs[i].efull));
      check($sformatf("v%0d_upd", i),   bus.upd_cnt,          vecs[i].eupd);
      check($sformatf("v%0d_drop", i),  32'(bus.drop_cnt),    32'(vecs[i].edrop));
    end

    // Drop counter saturation, then stat_clr beating a same-cycle increment.
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 8'(8'h40 + k), 0, 2'b11, 0, 0);
      sb_q.push_back('{8'(8'h40 + k), 1'b0, 2'b11});
    end
    for (int k = 0; k < 65533; k++) drive(1, 1, 8'h50, 0, 2'b01, 0, 0);
    drive(1, 0, 8'h00, 0, 2'b00, 0, 0);
    @(negedge clk);
    check("drop_fffe", 32'(bus.drop_cnt), 32'h0000_FFFE);
    for (int k = 0; k < 3; k++) drive(1, 1, 8'h51, 0, 2'b01, 1, 0);
    drive(1, 0, 8'h00, 0, 2'b00, 0, 0);
    @(negedge clk);
    check("drop_sat",       32'(bus.drop_cnt),  32'h0000_FFFF);
    check("misp_cnt_3",     bus.misp_cnt,       32'd3);
    check("upd_cnt_big",    bus.upd_cnt,        32'd65555);
    check("full_while_sat", 32'(bus.fifo_full), 32'd1);

    drive(1, 1, 8'h61, 0, 2'b01, 1, 1);
    drive(1, 0, 8'h00, 0, 2'b00, 0, 0);
    @(negedge clk);
    check("clr_upd",  bus.upd_cnt,        32'd0);
    check("clr_misp", bus.misp_cnt,       32'd0);
    check("clr_drop", 32'(bus.drop_cnt),  32'd0);
    check("clr_fifo", 32'(bus.fifo_full), 32'd1);
    drive(1, 1, 8'h62, 0, 2'b01, 1, 0);
    drive(1, 0, 8'h00, 0, 2'b00, 0, 0);
    @(negedge clk);
    check("post_clr_upd",  bus.upd_cnt,       32'd1);
    check("post_clr_misp", bus.misp_cnt,      32'd1);
    check("post_clr_drop", 32'(bus.drop_cnt), 32'd1);

    drive(0, 0, 8'h00, 0, 2'b00, 0, 0);
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    check("drain_done", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset with entries queued discards them all.
    for (int k = 0; k < 3; k++) drive(1, 1, 8'(8'h70 + k), 0, 2'b10, 0, 0);
    drive(1, 0, 8'h00, 0, 2'b00, 0, 0);
    @(negedge clk);
    check("pre_rst_addr", 32'(bus.bht_wr_addr), 32'h70);
    #2;
    rst_l           = 1'b0;
    bus.bht_rd_busy = 1'b0;
    #1;
    check("async_rst_wr_en", 32'(bus.bht_wr_en),   32'd0);
    check("async_rst_full",  32'(bus.fifo_full),   32'd0);
    check("async_rst_addr",  32'(bus.bht_wr_addr), 32'd0);
    check("async_rst_upd",   bus.upd_cnt,          32'd0);
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    repeat (20) @(negedge clk);
    check("no_write_after_rst", 32'(bus.bht_wr_en), 32'd0);
    check("sb_empty_end",       32'(sb_q.size()),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
